// File: rtl/tone_gen.sv
// Buzzer tone generator: beat-synchronised note latch, articulation gap,
// and octave-scaled square-wave output.
module tone_gen #(
    parameter int GAP_CYC = 500000,
    parameter int DIV0    = 95420,
    parameter int DIV1    = 85034,
    parameter int DIV2    = 75758,
    parameter int DIV3    = 71633,
    parameter int DIV4    = 63776,
    parameter int DIV5    = 56818,
    parameter int DIV6    = 50607
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       beat,
    input  logic [2:0] unable,
    input  logic [1:0] yinfu,
    output logic       buzz,
    output logic       active
);

    localparam int GW = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        (GAP_CYC > 1) ? GW'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        TONE
    } state_t;

    state_t      state;
    logic        s1, s2, s3;
    logic        live, armed;
    logic        beat_edge;
    logic        rest_in;
    logic [2:0]  note_q;
    logic [1:0]  oct_q;
    logic [GW-1:0] gap_cnt;
    logic [17:0] hp_cnt;
    logic [17:0] base;
    logic [17:0] div;

    // Beat synchroniser; armed only once beat has truly been seen low
    // after reset, so a beat held high across release is not an edge.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            live  <= 1'b0;
            armed <= 1'b0;
        end else begin
            s1    <= beat;
            s2    <= s1;
            s3    <= s2;
            live  <= 1'b1;
            armed <= armed | (live & ~s1);
        end
    end

    assign beat_edge = armed & s2 & ~s3;
    assign rest_in   = (unable == 3'b111) || (yinfu == 2'b00);

    // Half-period divisor for the latched note, scaled by octave.
    always_comb begin
        base = '0;
        case (note_q)
            3'd0:    base = 18'(DIV0);
            3'd1:    base = 18'(DIV1);
            3'd2:    base = 18'(DIV2);
            3'd3:    base = 18'(DIV3);
            3'd4:    base = 18'(DIV4);
            3'd5:    base = 18'(DIV5);
            3'd6:    base = 18'(DIV6);
            default: base = '0;
        endcase
        div = base;
        case (oct_q)
            2'b01:   div = base << 1;
            2'b11:   div = base >> 1;
            default: div = base;
        endcase
    end

    // Note FSM; a beat edge overrides every terminal-count action.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            note_q  <= 3'b111;
            oct_q   <= 2'b00;
            gap_cnt <= '0;
            hp_cnt  <= '0;
            buzz    <= 1'b0;
            active  <= 1'b0;
        end else if (beat_edge) begin
            note_q  <= unable;
            oct_q   <= yinfu;
            gap_cnt <= '0;
            hp_cnt  <= '0;
            buzz    <= 1'b0;
            active  <= 1'b0;
            state   <= rest_in ? IDLE : GAP;
        end else begin
            unique case (state)
                IDLE: begin
                    buzz   <= 1'b0;
                    active <= 1'b0;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= TONE;
                        gap_cnt <= '0;
                        hp_cnt  <= '0;
                        buzz    <= 1'b0;
                        active  <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                TONE: begin
                    if (hp_cnt == div - 18'd1) begin
                        hp_cnt <= '0;
                        buzz   <= ~buzz;
                    end else begin
                        hp_cnt <= hp_cnt + 18'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    buzz   <= 1'b0;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// Testbench for tone_gen: randomized notes checked against an
// analytic waveform model (gap length, half-period, rests, resets).
module tb_tone_gen;

    localparam int G = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       beat = 1'b0;
    logic [2:0] unable = 3'b111;
    logic [1:0] yinfu = 2'b00;
    logic       buzz, active, buzz0, active0;

    int errors = 0;
    int checks = 0;

    // model: current note, cycles since its latch, pending latch
    int m_note = 7, m_oct = 0, mk = 0;
    int pend = 0, p_note = 7, p_oct = 0, post = -1;
    logic [1:0] exp, exp0;
    int dv[7] = '{41, 36, 33, 30, 27, 25, 21};

    always #5 clk = ~clk;

    tone_gen #(
        .GAP_CYC(G), .DIV0(41), .DIV1(36), .DIV2(33), .DIV3(30),
        .DIV4(27), .DIV5(25), .DIV6(21)
    ) dut (
        .sysclk(clk), .rst(rst_n), .beat(beat), .unable(unable),
        .yinfu(yinfu), .buzz(buzz), .active(active)
    );

    tone_gen #(
        .GAP_CYC(0), .DIV0(41), .DIV1(36), .DIV2(33), .DIV3(30),
        .DIV4(27), .DIV5(25), .DIV6(21)
    ) dut0 (
        .sysclk(clk), .rst(rst_n), .beat(beat), .unable(unable),
        .yinfu(yinfu), .buzz(buzz0), .active(active0)
    );

    function automatic int div_of(int n, int o);
        int b = dv[n];
        if (o == 1) return b * 2;
        if (o == 3) return b / 2;
        return b;
    endfunction

    // {buzz, active} expected k cycles after a note was latched
    function automatic logic [1:0] ref_out(int n, int o, int k, int g);
        int ge = (g < 1) ? 1 : g;
        int t;
        if (n == 7 || o == 0 || k < ge) return 2'b00;
        t = k - ge;
        return {((t / div_of(n, o)) % 2) == 1, 1'b1};
    endfunction

    task automatic model_reset();
        m_note = 7; m_oct = 0; mk = 0;
        pend = 0; post = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                m_note = p_note; m_oct = p_oct;
                mk = 0; post = 0;
            end else begin
                mk++;
            end
        end else begin
            mk++;
            if (post >= 0) post++;
        end
        #1;
        exp  = ref_out(m_note, m_oct, mk, G);
        exp0 = ref_out(m_note, m_oct, mk, 0);
        if (post == 2) begin
            unable = 3'($urandom);
            yinfu  = 2'($urandom);
        end
        if (post == 3) beat = 1'b0;
    endtask

    task automatic rise_beat(input int n, input int o);
        unable = 3'(n);
        yinfu  = 2'(o);
        beat   = 1'b1;
        p_note = n; p_oct = o;
        pend   = 3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        beat  = 1'b0;
        #3;
        checks++;
        if ({buzz, active} !== 2'b00) begin
            errors++;
            $display("FAIL reset: got %b%b want 00", buzz, active);
        end
        checks++;
        if ({buzz0, active0} !== 2'b00) begin
            errors++;
            $display("FAIL reset0: got %b%b want 00", buzz0, active0);
        end
        repeat (3) tick();
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({buzz, active} !== exp) begin
                errors++;
                $display("FAIL post_reset c%0d: got %b%b want %b",
                         i, buzz, active, exp);
            end
        end
    endtask

    task automatic test_mid_octave();
        rise_beat(0, 2);
        for (int i = 0; i < G + 3 + 4 * 41; i++) begin
            tick();
            checks++;
            if ({buzz, active} !== exp) begin
                errors++;
                $display("FAIL mid c%0d: got %b%b want %b",
                         i, buzz, active, exp);
            end
            checks++;
            if ({buzz0, active0} !== exp0) begin
                errors++;
                $display("FAIL mid_gap0 c%0d: got %b%b want %b",
                         i, buzz0, active0, exp0);
            end
        end
    endtask

    task automatic test_octaves();
        int n_lo = G + 3 + 3 * 50;
        int n_hi = G + 3 + 4 * 12;
        rise_beat(5, 1);
        for (int i = 0; i < n_lo; i++) begin
            tick();
            checks++;
            if ({buzz, active} !== exp) begin
                errors++;
                $display("FAIL low_oct c%0d: got %b%b want %b",
                         i, buzz, active, exp);
            end
        end
        rise_beat(5, 3);
        for (int i = 0; i < n_hi; i++) begin
            tick();
            checks++;
            if ({buzz, active} !== exp) begin
                errors++;
                $display("FAIL high_oct c%0d: got %b%b want %b",
                         i, buzz, active, exp);
            end
        end
    endtask

    task automatic test_rest();
        int nn[3] = '{7, 3, 3};
        int oo[3] = '{2, 2, 0};
        int ll[3] = '{15, 60, 15};
        for (int j = 0; j < 3; j++) begin
            rise_beat(nn[j], oo[j]);
            for (int i = 0; i < ll[j]; i++) begin
                tick();
                checks++;
                if ({buzz, active} !== exp ||
                    {buzz0, active0} !== exp0) begin
                    errors++;
                    $display("FAIL rest%0d c%0d: got %b%b/%b%b want %b/%b",
                             j, i, buzz, active, buzz0, active0, exp, exp0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 2; j++) begin
            rise_beat(2, 2);
            for (int i = 0; i < G + 3 + 33 + 10; i++) begin
                tick();
                checks++;
                if ({buzz, active} !== exp) begin
                    errors++;
                    $display("FAIL b2b%0d c%0d: got %b%b want %b",
                             j, i, buzz, active, exp);
                end
            end
        end
    endtask

    task automatic test_collisions();
        int tgt[2] = '{G - 3, G + 27 - 3};
        int nxt[2] = '{4, 1};
        int i;
        rise_beat(4, 2);
        for (int j = 0; j < 2; j++) begin
            i = 0;
            while (!(pend == 0 && post > 0 && mk == tgt[j]) && i < 300) begin
                tick();
                i++;
                checks++;
                if ({buzz, active} !== exp) begin
                    errors++;
                    $display("FAIL coll%0d c%0d: got %b%b want %b",
                             j, i, buzz, active, exp);
                end
            end
            checks++;
            if (i >= 300) begin
                errors++;
                $display("FAIL coll%0d timeout: got mk=%0d want %0d",
                         j, mk, tgt[j]);
            end
            rise_beat(nxt[j], 2);
        end
        for (int k = 0; k < G + 3 + 2 * 36 + 5; k++) begin
            tick();
            checks++;
            if ({buzz, active} !== exp) begin
                errors++;
                $display("FAIL coll_tail c%0d: got %b%b want %b",
                         k, buzz, active, exp);
            end
        end
    endtask

    task automatic test_reset_mid_tone();
        int i = 0;
        rise_beat(1, 3);
        while (!(exp == 2'b11 && pend == 0) && i < 300) begin
            tick();
            i++;
        end
        checks++;
        if (i >= 300 || buzz !== 1'b1) begin
            errors++;
            $display("FAIL rmt_setup: got buzz=%b want 1", buzz);
        end
        #2;
        beat  = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({buzz, active, buzz0, active0} !== 4'b0000) begin
            errors++;
            $display("FAIL rmt_async: got %b%b/%b%b want 00/00",
                     buzz, active, buzz0, active0);
        end
        model_reset();
        repeat (2) tick();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k == 20) beat = 1'b0;
            tick();
            checks++;
            if ({buzz, active} !== 2'b00 ||
                {buzz0, active0} !== 2'b00) begin
                errors++;
                $display("FAIL rmt_idle c%0d: got %b%b/%b%b want 00/00",
                         k, buzz, active, buzz0, active0);
            end
        end
        rise_beat(6, 2);
        for (int k = 0; k < G + 3 + 2 * 25 + 5; k++) begin
            tick();
            checks++;
            if ({buzz, active} !== exp) begin
                errors++;
                $display("FAIL rmt_new c%0d: got %b%b want %b",
                         k, buzz, active, exp);
            end
        end
    endtask

    task automatic test_random();
        int n, o, len;
        for (int j = 0; j < 15; j++) begin
            n   = $urandom_range(0, 7);
            o   = $urandom_range(0, 3);
            len = $urandom_range(12, 200);
            rise_beat(n, o);
            for (int i = 0; i < len; i++) begin
                tick();
                checks++;
                if ({buzz, active} !== exp ||
                    {buzz0, active0} !== exp0) begin
                    errors++;
                    $display("FAIL rnd%0d n%0d o%0d c%0d: got %b%b/%b%b want %b/%b",
                             j, n, o, i, buzz, active, buzz0, active0,
                             exp, exp0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mid_octave();
        test_octaves();
        test_rest();
        test_back_to_back();
        test_collisions();
        test_reset_mid_tone();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
